// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (port 0 = core, port 1 = loader) with lock-hold FSM and registered read data.
// Build option DMEM_ARB_RR_EN: round-robin conflict resolution; otherwise port 0 always wins conflicts.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [1:0]      req_lock,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer on port i happens in the cycle where req_valid[i] && req_ready[i];
  // req_ready is never high without req_valid, at most one bit is high, and responses
  // (rsp_valid pulse one cycle later) cannot be stalled.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    grant;
  logic          accept;
  logic          sel;
  logic          sel_we;
  logic          sel_lock;
  logic          conflict_pick;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  assign addr0  = req_addr[AW-1:0];
  assign addr1  = req_addr[2*AW-1:AW];
  assign wdata0 = req_wdata[DW-1:0];
  assign wdata1 = req_wdata[2*DW-1:DW];

`ifdef DMEM_ARB_RR_EN
  logic last_q;  // index of the port most recently accepted

  assign conflict_pick = ~last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= sel;
    end
  end
`else
  assign conflict_pick = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (&req_valid) begin
          grant = conflict_pick ? 2'b10 : 2'b01;
        end else begin
          grant = req_valid;
        end
      end
      ST_LOCK0: grant = {1'b0, req_valid[0]};
      ST_LOCK1: grant = {req_valid[1], 1'b0};
      default:  grant = 2'b00;
    endcase
  end

  // Ready is masked by rst_n directly so nothing is granted while reset is held.
  assign req_ready = rst_n ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel       = req_ready[1];
  assign sel_we    = sel ? req_we[1]   : req_we[0];
  assign sel_lock  = sel ? req_lock[1] : req_lock[0];

  assign mem_a  = sel ? addr1  : addr0;
  assign mem_wd = sel ? wdata1 : wdata0;
  assign mem_we = accept & sel_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && sel_lock) begin
          state_d = sel ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0: begin
        if (req_ready[0] && !req_lock[0]) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK1: begin
        if (req_ready[1] && !req_lock[1]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= req_ready;
      if (accept) begin
        rsp_rdata <= sel_we ? '0 : mem_rd;
      end
    end
  end

  assign dbg_state = state_q;

  a_one_accept : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!rst_n) (req_ready & ~req_valid) == 2'b00);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: driver task predicts grants/memory outputs, a monitor
// matches each response strobe against a per-port expected queue.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int QW = DW + 16;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [1:0]      req_lock;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_a;
  logic [DW-1:0]   mem_wd;
  logic [DW-1:0]   mem_rd;
  logic [1:0]      dbg_state;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory under the arbiter: synchronous write, combinational read
  logic [DW-1:0] mem [0:63];
  logic [5:0]    mem_idx;
  assign mem_idx = mem_a[7:2];
  assign mem_rd  = mem[mem_idx];
  always @(posedge clk) if (mem_we) mem[mem_idx] <= mem_wd;

  // scoreboard
  logic [DW-1:0] ref_mem [0:63];
  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: apply one cycle of requests and check the predicted grant and memory outputs
  task automatic xfer(input string name, input logic [1:0] v, input logic [1:0] we,
                      input logic [1:0] lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] exp_rdy);
    logic          s;
    logic          e_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [15:0]   stamp;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
    s    = exp_rdy[1];
    e_we = (exp_rdy != 2'b00) && we[s];
    ea   = s ? a1 : a0;
    chk({name, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({name, " mem_we"}, 64'(mem_we), 64'(e_we));
    chk({name, " mem_a"}, 64'(mem_a), 64'(ea));
    chk({name, " mem_wd"}, 64'(mem_wd), 64'(s ? d1 : d0));
    if (exp_rdy != 2'b00) begin
      if (e_we) begin
        ed = '0;
        ref_mem[ea[7:2]] = s ? d1 : d0;
      end else begin
        ed = ref_mem[ea[7:2]];
      end
      stamp = 16'(cyc + 1);
      if (s) exp_q1.push_back({stamp, ed});
      else   exp_q0.push_back({stamp, ed});
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: every response strobe must match the queue head, on the predicted cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        logic          have;
        logic [QW-1:0] ent;
        have = (p == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        ent  = '0;
        if (have) ent = (p == 0) ? exp_q0[0] : exp_q1[0];
        if (rsp_valid[p]) begin
          if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp%0d unexpected: got rsp_valid=1 expected 0 (cycle %0d)", p, cyc);
          end else begin
            if (p == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
            chk($sformatf("rsp%0d timing", p), 64'(cyc), 64'(ent[QW-1:DW]));
            chk($sformatf("rsp%0d rdata", p), 64'(rsp_rdata), 64'(ent[DW-1:0]));
          end
        end else if (have && (ent[QW-1:DW] <= 16'(cyc))) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp%0d missing: got rsp_valid=0 expected 1 (cycle %0d)", p, cyc);
          if (p == 0) void'(exp_q0.pop_front());
          else        void'(exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_lock  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    #2;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    req_we    = 2'b00;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // write then read-back of the same word on port 0, starting the first cycle out of reset
    xfer("p0 write 0x10", 2'b01, 2'b01, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 2'b01);
    xfer("p0 read 0x10",  2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01);
    xfer("idle",          2'b00, 2'b00, 2'b00, 32'h30, 32'h34, 32'h5, 32'h6, 2'b00);
    xfer("p1 read 0x24",  2'b10, 2'b00, 2'b00, 32'h0, 32'h24, 32'h0, 32'h0, 2'b10);

    // six cycles of continuous conflict
    for (int k = 0; k < 6; k++) begin
`ifdef DMEM_ARB_RR_EN
      xfer($sformatf("conflict %0d", k), 2'b11, 2'b00, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0,
           (k % 2 == 0) ? 2'b01 : 2'b10);
`else
      xfer($sformatf("conflict %0d", k), 2'b11, 2'b00, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0, 2'b01);
`endif
    end

    // port 1 locks, port 0 is starved until port 1 unlocks
    xfer("p1 lock read", 2'b10, 2'b00, 2'b10, 32'h20, 32'h24, 32'h0, 32'h0, 2'b10);
    chk("state LOCK1", 64'(dbg_state), 64'd2);
    for (int k = 0; k < 3; k++) begin
      xfer($sformatf("p0 blocked %0d", k), 2'b01, 2'b00, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0, 2'b00);
    end
    xfer("p1 unlock write", 2'b11, 2'b10, 2'b00, 32'h20, 32'h28, 32'h0, 32'h12345678, 2'b10);
    chk("state after unlock", 64'(dbg_state), 64'd0);
    xfer("p0 after unlock", 2'b01, 2'b00, 2'b00, 32'h28, 32'h0, 32'h0, 32'h0, 2'b01);

    // same-cycle write (port 1) and read (port 0) of 0x04
`ifdef DMEM_ARB_RR_EN
    xfer("p1 wr 0x04 wins", 2'b11, 2'b10, 2'b00, 32'h04, 32'h04, 32'h0, 32'h1, 2'b10);
    xfer("p0 rd 0x04 new", 2'b01, 2'b00, 2'b00, 32'h04, 32'h04, 32'h0, 32'h0, 2'b01);
`else
    xfer("p0 rd 0x04 old", 2'b11, 2'b10, 2'b00, 32'h04, 32'h04, 32'h0, 32'h1, 2'b01);
    chk("old value 0x04", 64'(mem_rd), 64'hA500_0001);
    xfer("p1 wr 0x04", 2'b10, 2'b10, 2'b00, 32'h04, 32'h04, 32'h0, 32'h1, 2'b10);
    xfer("p0 rd 0x04 new", 2'b01, 2'b00, 2'b00, 32'h04, 32'h04, 32'h0, 32'h0, 2'b01);
`endif

    // reset during LOCK0 with a response pending
    xfer("p0 lock read", 2'b01, 2'b00, 2'b01, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01);
    chk("state LOCK0", 64'(dbg_state), 64'd1);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_lock  = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    chk("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid reset state", 64'(dbg_state), 64'd0);
    chk("mid reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer("p1 after reset", 2'b10, 2'b00, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0, 2'b10);

    for (int k = 0; k < 3; k++) begin
      xfer("drain", 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    end
    chk("q0 empty", 64'(exp_q0.size()), 64'd0);
    chk("q1 empty", 64'(exp_q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  2  per-requester request valid (bit 0 = core, bit 1 = loader).
REQ-006 The block SHALL have port req_ready  output  2  per-requester grant/accept.
REQ-007 The block SHALL have port req_we  input  2  per-requester write enable.
REQ-008 The block SHALL have port req_lock  input  2  per-requester lock-hold request.
REQ-009 The block SHALL have port req_addr  input  2*AW  concatenated byte addresses ({port1, port0}).
REQ-010 The block SHALL have port req_wdata  input  2*DW  concatenated write data ({port1, port0}).
REQ-011 The block SHALL have port rsp_valid  output  2  per-requester one-cycle response strobe.
REQ-012 The block SHALL have port rsp_rdata  output  DW  shared registered read data.
REQ-013 The block SHALL have port mem_we  output  1  data memory write enable.
REQ-014 The block SHALL have port mem_a  output  AW  data memory byte address.
REQ-015 The block SHALL have port mem_wd  output  DW  data memory write data.
REQ-016 The block SHALL have port mem_rd  input  DW  data memory combinational read data.

Function
REQ-017 Accept on port i SHALL be req_valid[i] && req_ready[i]; at most one port SHALL be accepted per cycle.
REQ-018 req_ready SHALL be combinational from req_valid, lock state and priority state; req_ready[i] SHALL be 0 whenever req_valid[i]=0.
REQ-019 On a single valid request with no lock held by the other port, that port SHALL be granted the same cycle.
REQ-020 On conflict (both valid, state IDLE), priority SHALL follow REQ-036/REQ-037.
REQ-021 FSM states SHALL be IDLE, LOCK0, LOCK1.
REQ-022 IDLE -> LOCKi SHALL occur on accept of port i with req_lock[i]=1.
REQ-023 In LOCKi only port i SHALL be grantable; the other port SHALL see req_ready=0 even if port i is not valid.
REQ-024 LOCKi -> IDLE SHALL occur on accept of port i with req_lock[i]=0; that transfer SHALL complete normally.
REQ-025 LOCKi accept with req_lock[i]=1 SHALL remain in LOCKi.
REQ-026 During a granted cycle mem_a, mem_wd SHALL carry the granted port's address/data unmodified; mem_we SHALL equal accept && req_we of that port.
REQ-027 With no grant mem_we SHALL be 0; mem_a, mem_wd SHALL carry port 0 values.
REQ-028 rsp_valid[i] SHALL pulse high exactly one cycle after an accept on port i, for one cycle, for reads and writes.
REQ-029 rsp_rdata SHALL be mem_rd registered at the read accept edge; after a write accept it SHALL be 0.
REQ-030 Back-to-back accepts SHALL be supported at one per cycle, alternating ports allowed; no response backpressure exists.
REQ-031 Write accepted cycle N followed by read of same address at N+1 SHALL return the new data at N+2.

Reset
REQ-032 rst_n low SHALL immediately force FSM to IDLE, rsp_valid=0, rsp_rdata=0, priority pointer to "port 1 last granted".
REQ-033 While rst_n low, req_ready SHALL be 0 and mem_we SHALL be 0.
REQ-034 Reset asserted mid-lock or with a response pending SHALL drop the lock and the pending response.
REQ-035 First accept SHALL be possible in the first cycle after rst_n rises.

Configuration
REQ-036 Macro DMEM_ARB_RR_EN defined: conflicts SHALL go to the port not most recently accepted; a 1-bit pointer SHALL update only on accept.
REQ-037 DMEM_ARB_RR_EN undefined: conflicts SHALL always go to port 0; no pointer register SHALL exist.

Verification
REQ-038 Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> mem_we=1 cycle N; rsp_valid[0] at N+1, N+2; rsp_rdata=0xDEADBEEF at N+2.
REQ-039 Both ports read continuously 6 cycles with DMEM_ARB_RR_EN -> grants 0,1,0,1,0,1; without macro -> port 0 all 6, port 1 none.
REQ-040 Port 1 read with lock=1, then port 0 valid 3 cycles while port 1 idle, then port 1 write with lock=0 -> port 0 req_ready=0 for all 3 cycles, granted cycle after unlock.
REQ-041 rst_n pulsed low during LOCK0 with read accepted prior cycle -> rsp_valid stays 0, FSM IDLE, port 1 granted first cycle after release.
REQ-042 Port 1 write 0x00000001 to 0x04 and port 0 read 0x04 same cycle (fixed priority) -> port 0 read returns old value; port 1 write lands next cycle; rsp_valid[1] one cycle later.
